mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_pkg.sv | 16 +
 rtl/mem_access_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// ============================================================================
// Module : mem_access_ctrl_pkg
// Brief  : Shared parameter defaults for the CPU-to-RAM access controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_access_ctrl_pkg;

    localparam int          c_adlines   = 8;
    localparam int          c_datalines = 8;
    localparam int unsigned c_ramsize   = 32;

endpackage : mem_access_ctrl_pkg

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module : mem_access_ctrl
// Brief  : Single-outstanding CPU load/store controller driving an external RAM
//          through a SETUP/STROBE handshake, with out-of-range error responses.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int          adlines   = c_adlines,
    parameter int          datalines = c_datalines,
    parameter int unsigned ramsize   = c_ramsize
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [adlines-1:0]   req_addr,
    input  logic [datalines-1:0] req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [datalines-1:0] resp_rdata,
    output logic                 resp_err,
    output logic [adlines-1:0]   ram_address,
    output logic [datalines-1:0] ram_datain,
    output logic                 ram_read,
    output logic                 ram_write,
    input  logic [datalines-1:0] ram_dataout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_we;
    logic [adlines-1:0]     r_addr;
    logic [datalines-1:0]   r_wdata;
    logic [datalines-1:0]   r_rdata;
    logic                   r_err;
    logic                   w_in_range;

    // Unsigned compare of the raw request address against the implemented depth.
    assign w_in_range = (32'(req_addr) < ramsize);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        ram_read    = 1'b0;
        ram_write   = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = w_in_range ? SETUP : RESP;
                end
            end
            SETUP: begin
                w_state_nxt = STROBE;
            end
            STROBE: begin
                ram_write   = r_we;
                ram_read    = !r_we;
                w_state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Request fields are captured only on acceptance; response fields change
    // only on entry to RESP, so they are stable for the whole response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_err   <= !w_in_range;
                        r_rdata <= '0;
                    end
                end
                STROBE: begin
                    r_rdata <= r_we ? '0 : ram_dataout;
                end
                default: begin
                end
            endcase
        end
    end

    assign ram_address = r_addr;
    assign ram_datain  = r_wdata;
    assign resp_rdata  = r_rdata;
    assign resp_err    = r_err;

endmodule : mem_access_ctrl

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module : tb_mem_access_ctrl
// Brief  : Directed vector table plus corner sequences for mem_access_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

    localparam int c_aw    = 8;
    localparam int c_dw    = 8;
    localparam int c_depth = 32;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [c_aw-1:0]   req_addr;
    logic [c_dw-1:0]   req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [c_dw-1:0]   resp_rdata;
    logic              resp_err;
    logic [c_aw-1:0]   ram_address;
    logic [c_dw-1:0]   ram_datain;
    logic              ram_read;
    logic              ram_write;
    logic [c_dw-1:0]   ram_dataout;

    int checks;
    int failures;

    logic [c_dw-1:0] ram_mem [256];
    logic [c_dw-1:0] exp_mem [c_depth];

    mem_access_ctrl #(
        .adlines   (c_aw),
        .datalines (c_dw),
        .ramsize   (c_depth)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .ram_address (ram_address),
        .ram_datain  (ram_datain),
        .ram_read    (ram_read),
        .ram_write   (ram_write),
        .ram_dataout (ram_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple external RAM: synchronous write, data visible while ram_read is high.
    always @(posedge clk) begin
        if (ram_write) ram_mem[ram_address] <= ram_datain;
    end
    assign ram_dataout = ram_read ? ram_mem[ram_address] : '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_req(input logic we, input logic [c_aw-1:0] addr,
                          input logic [c_dw-1:0] wdata, input logic [c_dw-1:0] exp_rdata,
                          input logic exp_err);
        int cyc;
        int nw;
        int nr;
        bit got;
        cyc = 0; nw = 0; nr = 0; got = 0;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wdata;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (ram_read && ram_write) chk("strobe_overlap", 32'd1, 32'd0);
            if (ram_write) begin
                nw++;
                chk("wr_address", 32'(ram_address), 32'(addr));
                chk("wr_datain", 32'(ram_datain), 32'(wdata));
            end
            if (ram_read) begin
                nr++;
                chk("rd_address", 32'(ram_address), 32'(addr));
            end
            if (resp_valid) got = 1;
        end
        chk("resp_latency", 32'(cyc), exp_err ? 32'd1 : 32'd3);
        chk("resp_err", 32'(resp_err), 32'(exp_err));
        chk("resp_rdata", 32'(resp_rdata), 32'(exp_rdata));
        chk("write_strobes", 32'(nw), (!exp_err && we) ? 32'd1 : 32'd0);
        chk("read_strobes", 32'(nr), (!exp_err && !we) ? 32'd1 : 32'd0);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    typedef struct {
        logic            we;
        logic [c_aw-1:0] addr;
        logic [c_dw-1:0] wdata;
        logic [c_dw-1:0] rdata;
        logic            err;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [c_aw-1:0] raddr [20];
        logic [c_dw-1:0] held;
        checks = 0;
        failures = 0;
        for (int i = 0; i < 256; i++) ram_mem[i] = '0;
        for (int i = 0; i < c_depth; i++) exp_mem[i] = '0;

        vecs[0] = '{we: 1'b1, addr: 8'd5,   wdata: 8'hA5, rdata: 8'h00, err: 1'b0};
        vecs[1] = '{we: 1'b0, addr: 8'd5,   wdata: 8'h00, rdata: 8'hA5, err: 1'b0};
        vecs[2] = '{we: 1'b0, addr: 8'd32,  wdata: 8'h00, rdata: 8'h00, err: 1'b1};
        vecs[3] = '{we: 1'b1, addr: 8'd31,  wdata: 8'h3C, rdata: 8'h00, err: 1'b0};
        vecs[4] = '{we: 1'b0, addr: 8'd31,  wdata: 8'hFF, rdata: 8'h3C, err: 1'b0};
        vecs[5] = '{we: 1'b1, addr: 8'd255, wdata: 8'h11, rdata: 8'h00, err: 1'b1};
        vecs[6] = '{we: 1'b1, addr: 8'd0,   wdata: 8'h5A, rdata: 8'h00, err: 1'b0};
        vecs[7] = '{we: 1'b0, addr: 8'd0,   wdata: 8'h00, rdata: 8'h5A, err: 1'b0};
        vecs[8] = '{we: 1'b0, addr: 8'd5,   wdata: 8'h00, rdata: 8'hA5, err: 1'b0};

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
        chk("rst_ram_address", 32'(ram_address), 32'd0);
        chk("rst_ram_datain", 32'(ram_datain), 32'd0);
        chk("rst_strobes", 32'({ram_read, ram_write}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err);
            if (vecs[i].we && !vecs[i].err) exp_mem[vecs[i].addr[4:0]] = vecs[i].wdata;
        end

        // Backpressure: response held five cycles while a competing request is offered.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd5;
        @(posedge clk);
        #1;
        req_addr = 8'd31; req_we = 1'b1; req_wdata = 8'hEE;
        begin
            int cyc;
            cyc = 0;
            while (!resp_valid && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            chk("bp_latency", 32'(cyc), 32'd3);
        end
        held = resp_rdata;
        chk("bp_rdata", 32'(held), 32'hA5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid_hold", 32'(resp_valid), 32'd1);
            chk("bp_rdata_hold", 32'(resp_rdata), 32'(held));
            chk("bp_not_ready", 32'(req_ready), 32'd0);
            chk("bp_no_strobe", 32'({ram_read, ram_write}), 32'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_back_idle", 32'({req_ready, resp_valid, ram_write}), 32'b100);
        end
        chk("bp_store_ignored", 32'(ram_mem[31]), 32'h3C);

        // Reset during STROBE of a store aborts it with no response.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd7; req_wdata = 8'h77;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        begin
            int cyc;
            cyc = 0;
            while (!ram_write && cyc < 10) begin
                @(negedge clk);
                cyc++;
            end
            chk("rst_strobe_reached", 32'(ram_write), 32'd1);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_strobes", 32'({ram_read, ram_write}), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_address", 32'(ram_address), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_ready", 32'(req_ready), 32'd1);
        repeat (4) begin
            @(negedge clk);
            chk("abort_quiet", 32'({resp_valid, ram_read, ram_write}), 32'd0);
        end
        exp_mem[7] = ram_mem[7];

        // Random back-to-back stores then loads against the scoreboard.
        for (int i = 0; i < 20; i++) begin
            logic [c_dw-1:0] d;
            raddr[i] = 8'($urandom_range(0, c_depth - 1));
            d = 8'($urandom_range(0, 255));
            do_req(1'b1, raddr[i], d, 8'h00, 1'b0);
            exp_mem[raddr[i][4:0]] = d;
        end
        for (int i = 0; i < 20; i++) begin
            do_req(1'b0, raddr[i], 8'h00, exp_mem[raddr[i][4:0]], 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Strobe exclusivity is also watched continuously, outside the request tasks.
    always @(negedge clk) begin
        if (rst_n && ram_read && ram_write) begin
            failures++;
            $display("FAIL strobe_exclusive: read=%0b write=%0b required not both", ram_read, ram_write);
        end
    end

endmodule : tb_mem_access_ctrl

`default_nettype wire
